// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU hold busy for a fixed, parameterised number of cycles
// and then commit the full result to HI/LO together with a one-cycle done
// pulse. MTHI/MTLO write HI/LO directly in a single cycle while idle.
module mdu_multicycle #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic               accept;
    logic               finish;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] result;

    // Full-width signed product; operands are sign-extended explicitly so the
    // multiply is done at 2*WIDTH without relying on context sizing rules.
    function automatic logic [2*WIDTH-1:0] mul_signed(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ax;
        logic signed [2*WIDTH-1:0] bx;
        logic signed [2*WIDTH-1:0] p;
        ax = {{WIDTH{a[WIDTH-1]}}, a};
        bx = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ax * bx;
        return p;
    endfunction

    // Full-width unsigned product.
    function automatic logic [2*WIDTH-1:0] mul_unsigned(input logic [WIDTH-1:0] a,
                                                        input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ax;
        logic [2*WIDTH-1:0] bx;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        return ax * bx;
    endfunction

    // Signed divide returning {remainder, quotient}. Works on magnitudes so the
    // most-negative dividend (whose magnitude still fits in WIDTH unsigned bits)
    // wraps to itself when divided by -1, with a zero remainder. Quotient
    // truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [2*WIDTH-1:0] div_signed(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic [WIDTH-1:0]        ua;
        logic [WIDTH-1:0]        ub;
        logic [WIDTH-1:0]        uq;
        logic [WIDTH-1:0]        ur;
        logic signed [WIDTH-1:0] quo;
        logic signed [WIDTH-1:0] rem;
        ua  = a[WIDTH-1] ? (~a + 1'b1) : a;
        ub  = b[WIDTH-1] ? (~b + 1'b1) : b;
        if (ub == '0) ub = CNT_W'(1) == CNT_ONE ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
        uq  = ua / ub;
        ur  = ua % ub;
        quo = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~uq + 1'b1) : uq;
        rem = a[WIDTH-1] ? (~ur + 1'b1) : ur;
        return {rem, quo};
    endfunction

    // Unsigned divide returning {remainder, quotient}; a zero divisor is
    // replaced so no X is produced (the result is discarded in that case).
    function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] a,
                                                        input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] bd;
        bd = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
        return {a % bd, a / bd};
    endfunction

    assign accept      = (state == IDLE) && start && !op[2];
    assign finish      = (state == BUSY) && (cnt == CNT_ONE);
    assign div_by_zero = op_q[1] && (b_q == '0);
    assign busy        = (state == BUSY);
    assign done        = done_q;

    // Result selection from the latched operands; only committed on finish.
    always_comb begin
        result = '0;
        case (op_q)
            2'd0:    result = mul_signed(a_q, b_q);
            2'd1:    result = mul_unsigned(a_q, b_q);
            2'd2:    result = div_signed(a_q, b_q);
            default: result = div_unsigned(a_q, b_q);
        endcase
    end

    // Control FSM: IDLE accepts mult/div, BUSY counts down to completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= op[1] ? DIV_LOAD : MULT_LOAD;
                        state <= BUSY;
                    end
                end
                default: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Operand capture on acceptance; held stable for the whole busy period.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op[1:0];
        end
    end

    // HI/LO update: result commit on finish, direct moves while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (finish) begin
            if (!div_by_zero) begin
                HI <= result[2*WIDTH-1:WIDTH];
                LO <= result[WIDTH-1:0];
            end
        end else if ((state == IDLE) && start) begin
            if (op == OP_MTHI) HI <= A;
            if (op == OP_MTLO) LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: directed scenarios plus randomized operations,
// checked cycle by cycle against a plain-arithmetic model of HI/LO.
module tb_mdu_multicycle;

    localparam int W      = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int           n_vec;
    int           n_err;
    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    mdu_multicycle #(
        .WIDTH      (W),
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one accepted operation on the HI/LO model.
    task automatic apply_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned pu;
        longint          q;
        longint          r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (o)
            3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                hi_m = pu[63:32]; lo_m = pu[31:0];
            end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                lo_m = q[31:0]; hi_m = r[31:0];
            end
            3'd3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one operation in the current cycle and follow it to completion.
    // Optionally drives a stray start (inj_op/inj_a) in busy cycle inj_k.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_k, input logic [2:0] inj_op, input logic [W-1:0] inj_a);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        int           n;
        h0 = hi_m;
        l0 = lo_m;
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; op = 3'd7;
        if (o <= 3'd3) begin
            n = o[1] ? DIV_N : MULT_N;
            for (int k = 1; k <= n; k++) begin
                if (k == inj_k) begin
                    start = 1'b1; op = inj_op; A = inj_a;
                end else begin
                    start = 1'b0; op = 3'd7;
                end
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
                check("hi_hold", HI, h0);
                check("lo_hold", LO, l0);
                tick();
            end
            start = 1'b0; op = 3'd7;
            apply_model(o, a, b);
            check("busy_end", busy, 0);
            check("done_end", done, 1);
            check("hi_res", HI, hi_m);
            check("lo_res", LO, lo_m);
        end else begin
            apply_model(o, a, b);
            check("busy_mt", busy, 0);
            check("done_mt", done, 0);
            check("hi_mt", HI, hi_m);
            check("lo_mt", LO, lo_m);
        end
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           gap;

        n_vec = 0; n_err = 0;
        hi_m = '0; lo_m = '0;
        reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
        tick();
        start = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        run_op(3'd4, 32'h1234, 32'h0, 0, 3'd7, '0);
        run_op(3'd5, 32'h5678, 32'h0, 0, 3'd7, '0);
        check("mt_hi", HI, 32'h1234);
        check("mt_lo", LO, 32'h5678);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 3'd7, '0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        tick();
        check("done_once", done, 0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 3'd7, '0);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd7, '0);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2, 0, 3'd7, '0);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd7, '0);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);
        run_op(3'd3, 32'd1234, 32'd0, 0, 3'd7, '0);
        check("dz_lo", LO, 32'h8000_0000);
        check("dz_hi", HI, 32'd0);

        // MTLO issued mid-operation must be ignored.
        run_op(3'd0, 32'd1000, 32'hFFFF_FFF0, 2, 3'd5, 32'd9);
        check("ign_lo", LO, 32'hFFFF_C180);
        check("ign_hi", HI, 32'hFFFF_FFFF);

        // Reset in busy cycle 3 aborts the operation and clears HI/LO.
        start = 1'b1; op = 3'd0; A = 32'd77; B = 32'd5;
        tick();
        start = 1'b0; op = 3'd7;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        check("abort_busy", busy, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        for (int k = 0; k < MULT_N + 2; k++) begin
            check("abort_nodone", done, 0);
            tick();
        end

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 10));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb, 0, 3'd7, '0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("idle_done", done, 0);
                check("idle_hi", HI, hi_m);
                check("idle_lo", LO, lo_m);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
